// File: rtl/neuron_timestep_scheduler.sv
// Sequences one timestep across NUM_NEURONS cores, one neuron at a time, and queues spiking indices.
// Optional handshake watchdog: define NEURON_SCHED_WATCHDOG_EN.
module neuron_timestep_scheduler #(
   parameter int NUM_NEURONS = 16,
   parameter int IDX_W       = 4,
   parameter int FIFO_DEPTH  = 8,
   parameter int WDOG_CYCLES = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   timestep_start,
   output logic                   timestep_done,
   output logic                   sched_busy,
   output logic [IDX_W-1:0]       cur_addr,
   input  logic [31:0]            cur_data,
   output logic [31:0]            core_current,
   output logic [NUM_NEURONS-1:0] core_start_update,
   output logic [NUM_NEURONS-1:0] core_start_reset,
   input  logic [NUM_NEURONS-1:0] core_busy,
   input  logic [NUM_NEURONS-1:0] core_spike,
   output logic                   spike_valid,
   output logic [IDX_W-1:0]       spike_idx,
   input  logic                   spike_ready,
   output logic [IDX_W:0]         spike_count,
   output logic                   err_timeout
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = PTR_W + 1;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_LOAD, S_START, S_ACK, S_WAIT,
      S_RST_START, S_RST_ACK, S_RST_WAIT, S_EMIT, S_NEXT
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      cur_q, cur_d;
   logic [IDX_W:0]   cnt_q, cnt_d;
   logic             done_q, done_d;

   logic [FIFO_DEPTH-1:0][IDX_W-1:0] mem_q, mem_d;
   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             valid_q, valid_d;
   logic             push, pop, full;

   logic sel_busy, sel_spike;
   assign sel_busy  = core_busy[idx_q];
   assign sel_spike = core_spike[idx_q];

   // A pop in the same cycle frees a slot, so a full FIFO can still accept the push.
   assign pop  = valid_q && spike_ready;
   assign full = (occ_q == OCC_W'(FIFO_DEPTH));

`ifdef NEURON_SCHED_WATCHDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic              err_q, err_d, waiting, wd_fire;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cur_d   = cur_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      push    = 1'b0;
      case (state_q)
         S_IDLE: if (timestep_start) begin
            idx_d   = '0;
            cnt_d   = '0;
            state_d = S_FETCH;
         end
         S_FETCH:     state_d = S_LOAD;
         S_LOAD: begin
            cur_d   = cur_data;
            state_d = S_START;
         end
         S_START:     state_d = S_ACK;
         S_ACK:       if (sel_busy) state_d = S_WAIT;
         S_WAIT:      if (!sel_busy) state_d = sel_spike ? S_RST_START : S_NEXT;
         S_RST_START: state_d = S_RST_ACK;
         S_RST_ACK:   if (sel_busy) state_d = S_RST_WAIT;
         S_RST_WAIT:  if (!sel_busy) state_d = S_EMIT;
         S_EMIT: if (!full || pop) begin
            push    = 1'b1;
            cnt_d   = cnt_q + (IDX_W+1)'(1);
            state_d = S_NEXT;
         end
         S_NEXT: if (idx_q == IDX_W'(NUM_NEURONS - 1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_FETCH;
         end
         default:     state_d = S_IDLE;
      endcase

`ifdef NEURON_SCHED_WATCHDOG_EN
      // Timeout only fires when the handshake has not progressed this cycle; the spike is dropped.
      waiting = state_q inside {S_ACK, S_WAIT, S_RST_ACK, S_RST_WAIT};
      wd_fire = waiting && (state_d == state_q) && (wdog_q == WDOG_W'(WDOG_CYCLES - 1));
      if (wd_fire) state_d = S_NEXT;
      err_d  = err_q | wd_fire;
      wdog_d = (waiting && state_d == state_q) ? wdog_q + WDOG_W'(1) : '0;
`endif

      mem_d = mem_q;
      if (push) mem_d[wr_q] = idx_q;
      wr_d  = wr_q + PTR_W'(push);
      rd_d  = rd_q + PTR_W'(pop);
      occ_d = occ_q;
      if (push && !pop) occ_d = occ_q + OCC_W'(1);
      if (pop && !push) occ_d = occ_q - OCC_W'(1);
      valid_d = (occ_d != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cur_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         mem_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         occ_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cur_q   <= cur_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         occ_q   <= occ_d;
         valid_q <= valid_d;
      end
   end

`ifdef NEURON_SCHED_WATCHDOG_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wdog_q <= wdog_d;
         err_q  <= err_d;
      end
   end
   assign err_timeout = err_q;
`else
   assign err_timeout = 1'b0;
`endif

   assign cur_addr          = idx_q;
   assign core_current      = cur_q;
   assign core_start_update = (state_q == S_START)     ? (NUM_NEURONS'(1) << idx_q) : '0;
   assign core_start_reset  = (state_q == S_RST_START) ? (NUM_NEURONS'(1) << idx_q) : '0;
   assign timestep_done     = done_q;
   assign sched_busy        = (state_q != S_IDLE);
   assign spike_valid       = valid_q;
   assign spike_idx         = mem_q[rd_q];
   assign spike_count       = cnt_q;

endmodule

// File: tb/tb_neuron_timestep_scheduler.sv
// Randomized bench for neuron_timestep_scheduler: behavioural cores and current memory, event logs vs. expected sequences.
module tb_neuron_timestep_scheduler;
   localparam int N  = 4;
   localparam int IW = 2;
   localparam int FD = 2;
   localparam int WD = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          timestep_start = 1'b0;
   logic          timestep_done, sched_busy, spike_valid, err_timeout;
   logic [IW-1:0] cur_addr, spike_idx;
   logic [31:0]   cur_data, core_current;
   logic [N-1:0]  core_start_update, core_start_reset, core_busy, core_spike;
   logic          spike_ready;
   logic [IW:0]   spike_count;

   always #5 clk = ~clk;

   neuron_timestep_scheduler #(.NUM_NEURONS(N), .IDX_W(IW), .FIFO_DEPTH(FD), .WDOG_CYCLES(WD)) dut (
      .clk(clk), .rst(rst), .timestep_start(timestep_start), .timestep_done(timestep_done),
      .sched_busy(sched_busy), .cur_addr(cur_addr), .cur_data(cur_data), .core_current(core_current),
      .core_start_update(core_start_update), .core_start_reset(core_start_reset),
      .core_busy(core_busy), .core_spike(core_spike), .spike_valid(spike_valid),
      .spike_idx(spike_idx), .spike_ready(spike_ready), .spike_count(spike_count),
      .err_timeout(err_timeout));

   int tests = 0;
   int fails = 0;

   // Environment: current memory with 1-cycle read latency, cores that go busy after a trigger.
   logic [31:0] cur_mem [N];
   int          busy_len [N];
   int          busy_tmr [N];
   logic [N-1:0] spike_plan = '0;
   logic [N-1:0] hang_mask  = '0;
   int          ready_mode  = 1;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_data <= '0;
         for (int i = 0; i < N; i++) busy_tmr[i] <= 0;
      end else begin
         cur_data <= cur_mem[cur_addr];
         for (int i = 0; i < N; i++)
            if ((core_start_update[i] || core_start_reset[i]) && !hang_mask[i]) busy_tmr[i] <= busy_len[i];
            else if (busy_tmr[i] > 0) busy_tmr[i] <= busy_tmr[i] - 1;
      end
   end

   always_comb begin
      core_busy = '0;
      for (int i = 0; i < N; i++) core_busy[i] = (busy_tmr[i] != 0);
      core_spike = spike_plan;
   end

   initial begin
      spike_ready = 1'b1;
      forever begin
         @(posedge clk); #2;
         spike_ready = (ready_mode == 1) ? 1'b1 : (ready_mode == 2) ? 1'($urandom % 2) : 1'b0;
      end
   end

   // Monitor: event logs hold one nibble (index+1) per event in order of occurrence.
   logic [63:0] upd_log, rst_log, pop_log;
   int upd_cnt, done_cnt, cur_bad, onehot_bad, busy_bad;

   task automatic clear_mon();
      upd_log = '0; rst_log = '0; pop_log = '0;
      upd_cnt = 0; done_cnt = 0; cur_bad = 0; onehot_bad = 0; busy_bad = 0;
   endtask

   initial begin
      clear_mon();
      forever begin
         @(negedge clk);
         if (!rst) begin
            if ($countones(core_start_update) > 1 || $countones(core_start_reset) > 1) onehot_bad++;
            for (int i = 0; i < N; i++) begin
               if (core_start_update[i]) begin
                  upd_log = {upd_log[59:0], 4'(i + 1)};
                  upd_cnt++;
                  if (core_current !== cur_mem[i]) cur_bad++;
               end
               if (core_start_reset[i]) rst_log = {rst_log[59:0], 4'(i + 1)};
            end
            if (spike_valid && spike_ready) pop_log = {pop_log[59:0], 4'(int'(spike_idx) + 1)};
            if (timestep_done) begin
               done_cnt++;
               if (sched_busy) busy_bad++;
            end
         end
      end
   end

   // Reference: the sweep visits every neuron in ascending order; spiking ones are reset and emitted in that order.
   function automatic logic [63:0] exp_seq(input logic [N-1:0] m);
      logic [63:0] s = '0;
      for (int i = 0; i < N; i++) if (m[i]) s = {s[59:0], 4'(i + 1)};
      return s;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic setup(input logic [N-1:0] spk, input bit zero_cur);
      spike_plan = spk;
      for (int i = 0; i < N; i++) begin
         cur_mem[i]  = zero_cur ? 32'h0 : $urandom;
         busy_len[i] = $urandom_range(1, 4);
      end
      clear_mon();
   endtask

   task automatic do_sweep(input int budget, output bit ok);
      timestep_start = 1'b1;
      cyc(1);
      timestep_start = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (done_cnt != 0) begin ok = 1'b1; break; end
         cyc(1);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc(3);
      tests++; if (sched_busy !== 1'b0 || timestep_done !== 1'b0) begin fails++;
         $display("FAIL reset_ctrl busy=%b done=%b required 0 0", sched_busy, timestep_done); end
      tests++; if (spike_valid !== 1'b0 || spike_count !== '0) begin fails++;
         $display("FAIL reset_fifo valid=%b count=%0d required 0 0", spike_valid, spike_count); end
      tests++; if (core_start_update !== '0 || core_start_reset !== '0) begin fails++;
         $display("FAIL reset_pulses upd=%b rst=%b required 0", core_start_update, core_start_reset); end
      tests++; if (core_current !== '0 || cur_addr !== '0 || err_timeout !== 1'b0) begin fails++;
         $display("FAIL reset_data cur=%h addr=%0d err=%b required 0", core_current, cur_addr, err_timeout); end
      rst = 1'b0;
      cyc(2);
   endtask

   task automatic test_happy();
      bit ok;
      setup('0, 1'b1);
      ready_mode = 1;
      timestep_start = 1'b1;
      tests++; if (sched_busy !== 1'b0) begin fails++;
         $display("FAIL happy_busy_pre got=%b required 0", sched_busy); end
      cyc(1);
      timestep_start = 1'b0;
      tests++; if (sched_busy !== 1'b1) begin fails++;
         $display("FAIL happy_busy_rise got=%b required 1", sched_busy); end
      ok = 1'b0;
      for (int c = 0; c < 500; c++) begin
         if (done_cnt != 0) begin ok = 1'b1; break; end
         cyc(1);
      end
      cyc(4);
      tests++; if (!ok) begin fails++; $display("FAIL happy_timeout done never seen, required within 500 cycles"); end
      tests++; if (upd_log !== exp_seq('1) || rst_log !== '0) begin fails++;
         $display("FAIL happy_pulses upd=%h rst=%h required %h 0", upd_log, rst_log, exp_seq('1)); end
      tests++; if (spike_count !== '0 || done_cnt !== 1 || busy_bad !== 0) begin fails++;
         $display("FAIL happy_done count=%0d dones=%0d busy_at_done=%0d required 0 1 0", spike_count, done_cnt, busy_bad); end
   endtask

   task automatic test_spike_capture();
      bit ok;
      setup(4'b0100, 1'b0);
      ready_mode = 1;
      do_sweep(500, ok);
      cyc(4);
      tests++; if (!ok) begin fails++; $display("FAIL spike_timeout done never seen"); end
      tests++; if (rst_log !== exp_seq(4'b0100) || pop_log !== exp_seq(4'b0100)) begin fails++;
         $display("FAIL spike_events rst=%h pop=%h required %h", rst_log, pop_log, exp_seq(4'b0100)); end
      tests++; if (spike_count !== 3'd1 || cur_bad !== 0) begin fails++;
         $display("FAIL spike_count count=%0d cur_bad=%0d required 1 0", spike_count, cur_bad); end
   endtask

   task automatic test_random();
      bit ok;
      logic [N-1:0] spk;
      for (int it = 0; it < 8; it++) begin
         spk = N'($urandom);
         setup(spk, 1'b0);
         ready_mode = 2;
         do_sweep(1000, ok);
         ready_mode = 1;
         cyc(FD + 4);
         tests++; if (!ok || done_cnt !== 1) begin fails++;
            $display("FAIL rand%0d_done ok=%b dones=%0d required 1 1", it, ok, done_cnt); end
         tests++; if (upd_log !== exp_seq('1) || rst_log !== exp_seq(spk) || pop_log !== exp_seq(spk)) begin fails++;
            $display("FAIL rand%0d_events upd=%h rst=%h pop=%h required %h %h %h", it, upd_log, rst_log, pop_log,
                     exp_seq('1), exp_seq(spk), exp_seq(spk)); end
         tests++; if (int'(spike_count) != $countones(spk) || cur_bad !== 0 || onehot_bad !== 0) begin fails++;
            $display("FAIL rand%0d_count count=%0d cur_bad=%0d onehot_bad=%0d required %0d 0 0", it, spike_count,
                     cur_bad, onehot_bad, $countones(spk)); end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      setup('1, 1'b0);
      ready_mode = 0;
      timestep_start = 1'b1;
      cyc(1);
      timestep_start = 1'b0;
      cyc(200);
      tests++; if (upd_log !== exp_seq(4'b0111) || rst_log !== exp_seq(4'b0111) || done_cnt !== 0) begin fails++;
         $display("FAIL bp_stall upd=%h rst=%h dones=%0d required %h %h 0", upd_log, rst_log, done_cnt,
                  exp_seq(4'b0111), exp_seq(4'b0111)); end
      tests++; if (spike_valid !== 1'b1 || spike_idx !== 2'd0 || spike_count !== 3'd2 || sched_busy !== 1'b1) begin fails++;
         $display("FAIL bp_head valid=%b idx=%0d count=%0d busy=%b required 1 0 2 1", spike_valid, spike_idx,
                  spike_count, sched_busy); end
      ready_mode = 1;
      ok = 1'b0;
      for (int c = 0; c < 500; c++) begin
         if (done_cnt != 0) begin ok = 1'b1; break; end
         cyc(1);
      end
      cyc(FD + 4);
      tests++; if (!ok || pop_log !== exp_seq('1) || spike_count !== 3'd4) begin fails++;
         $display("FAIL bp_drain ok=%b pop=%h count=%0d required 1 %h 4", ok, pop_log, spike_count, exp_seq('1)); end
      tests++; if (spike_valid !== 1'b0) begin fails++;
         $display("FAIL bp_empty valid=%b required 0", spike_valid); end
   endtask

   task automatic test_ignored_start();
      bit ok;
      setup(4'b1001, 1'b0);
      ready_mode = 1;
      timestep_start = 1'b1;
      cyc(1);
      timestep_start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc(4);
         timestep_start = 1'b1;
         cyc(1);
         timestep_start = 1'b0;
      end
      ok = 1'b0;
      for (int c = 0; c < 500; c++) begin
         if (done_cnt != 0) begin ok = 1'b1; break; end
         cyc(1);
      end
      cyc(20);
      tests++; if (!ok || done_cnt !== 1 || upd_log !== exp_seq('1)) begin fails++;
         $display("FAIL ign_start ok=%b dones=%0d upd=%h required 1 1 %h", ok, done_cnt, upd_log, exp_seq('1)); end
      tests++; if (sched_busy !== 1'b0 || pop_log !== exp_seq(4'b1001)) begin fails++;
         $display("FAIL ign_idle busy=%b pop=%h required 0 %h", sched_busy, pop_log, exp_seq(4'b1001)); end
   endtask

   task automatic test_async_reset();
      bit ok;
      setup(4'b0001, 1'b0);
      cur_mem[1]  = 32'hDEAD_BEEF;
      busy_len[1] = 10;
      ready_mode  = 0;
      timestep_start = 1'b1;
      cyc(1);
      timestep_start = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (upd_cnt >= 2) begin ok = 1'b1; break; end
         cyc(1);
      end
      cyc(3);
      tests++; if (!ok || sched_busy !== 1'b1 || spike_valid !== 1'b1 || core_current !== 32'hDEAD_BEEF) begin fails++;
         $display("FAIL arst_pre ok=%b busy=%b valid=%b cur=%h required 1 1 1 deadbeef", ok, sched_busy,
                  spike_valid, core_current); end
      #2 rst = 1'b1;
      #1;
      tests++; if (sched_busy !== 1'b0 || spike_valid !== 1'b0 || spike_count !== '0 || timestep_done !== 1'b0) begin fails++;
         $display("FAIL arst_ctrl busy=%b valid=%b count=%0d done=%b required 0 0 0 0", sched_busy, spike_valid,
                  spike_count, timestep_done); end
      tests++; if (core_current !== '0 || cur_addr !== '0 || core_start_update !== '0 || core_start_reset !== '0) begin fails++;
         $display("FAIL arst_data cur=%h addr=%0d upd=%b rst=%b required 0", core_current, cur_addr,
                  core_start_update, core_start_reset); end
      cyc(2);
      rst = 1'b0;
      cyc(2);
      setup(4'b0010, 1'b0);
      ready_mode = 1;
      do_sweep(500, ok);
      cyc(4);
      tests++; if (!ok || upd_log !== exp_seq('1) || pop_log !== exp_seq(4'b0010) || spike_count !== 3'd1) begin fails++;
         $display("FAIL arst_restart ok=%b upd=%h pop=%h count=%0d required 1 %h %h 1", ok, upd_log, pop_log,
                  spike_count, exp_seq('1), exp_seq(4'b0010)); end
   endtask

`ifdef NEURON_SCHED_WATCHDOG_EN
   task automatic test_watchdog();
      bit ok;
      setup(4'b0010, 1'b0);
      hang_mask  = 4'b0010;
      ready_mode = 1;
      do_sweep(1000, ok);
      cyc(4);
      hang_mask = '0;
      tests++; if (!ok || err_timeout !== 1'b1) begin fails++;
         $display("FAIL wdog_err ok=%b err=%b required 1 1", ok, err_timeout); end
      tests++; if (upd_log !== exp_seq('1) || rst_log !== '0 || spike_count !== '0) begin fails++;
         $display("FAIL wdog_sweep upd=%h rst=%h count=%0d required %h 0 0", upd_log, rst_log, spike_count,
                  exp_seq('1)); end
   endtask
`else
   task automatic test_watchdog();
      tests++; if (err_timeout !== 1'b0) begin fails++;
         $display("FAIL no_wdog err=%b required 0", err_timeout); end
   endtask
`endif

   initial begin
      for (int i = 0; i < N; i++) begin
         cur_mem[i]  = '0;
         busy_len[i] = 1;
      end
      test_reset();
      test_happy();
      test_spike_capture();
      test_random();
      test_backpressure();
      test_ignored_start();
      test_async_reset();
      test_watchdog();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout simulation exceeded time limit");
      $fatal(1, "time limit");
   end
endmodule
